// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush controller for a 5-stage pipeline.
// Produces per-stage register enables and bubble clears with zero-cycle
// latency. These come from the current state, the vector beat counter and
// the hazard inputs.
//
// Optional feature: define STALL_COUNTER_EN to build the saturating
// front-end stall counter. Without it, stall_count is tied to zero.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   mem_req/mem_ready - data-memory access pending / completing (freeze)
//   branch_taken      - EX resolved a taken branch or jump (flush IF/ID, ID/EX)
//   vec_start/beats   - multi-beat vector op in EX, beat count N
//   load_use          - load-use hazard between ID and EX
//   *_en              - pipeline register enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   *_clr             - bubble insert; a clear overrides its register's enable
//   vec_busy          - controller is in the VEC state
//   stall_count       - cycles with pc_en low (STALL_COUNTER_EN only)
module pipeline_stall_ctrl #(
    parameter int unsigned BEAT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              branch_taken,
    input  logic              vec_start,
    input  logic [BEAT_W-1:0] vec_beats,
    input  logic              load_use,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_clr,
    output logic              idex_clr,
    output logic              exmem_clr,
    output logic              vec_busy,
    output logic [15:0]       stall_count
);

    typedef enum logic [0:0] {
        RUN = 1'b0,
        VEC = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] rem_q, rem_d;
    logic              freeze;

    // An outstanding memory access freezes the whole pipe and all state.
    assign freeze   = mem_req & ~mem_ready;
    assign vec_busy = (state_q == VEC);

    // State and beat-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and enable/clear decode.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;

        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        ifid_clr = 1'b1;
                        idex_clr = 1'b1;
                    end else if (vec_start && (vec_beats > BEAT_W'(1))) begin
                        // First beat occupies this cycle; N-2 more stall cycles in VEC.
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_clr = 1'b1;
                        rem_d     = vec_beats - BEAT_W'(1);
                        state_d   = VEC;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_clr = 1'b1;
                    end
                end
                VEC: begin
                    if (rem_q > BEAT_W'(1)) begin
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_clr = 1'b1;
                        rem_d     = rem_q - BEAT_W'(1);
                    end else begin
                        // Final beat: front end released this cycle.
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end
                default: begin
                    rem_d   = '0;
                    state_d = RUN;
                end
            endcase
        end
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_count_q;

    // Saturating count of cycles where the PC is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 16'h0000;
        end else if (!pc_en && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'h0001;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter BEAT_W, default 4, width of the vector beat count.
REQ-002 SHALL have port clk, in, 1: the only clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-004 SHALL have port mem_req, in, 1: MEM stage holds a data-memory access.
REQ-005 SHALL have port mem_ready, in, 1: data memory completes the access this cycle.
REQ-006 SHALL have port branch_taken, in, 1: EX resolved a taken branch or jump.
REQ-007 SHALL have port vec_start, in, 1: EX holds a multi-beat vector op (RUN state only).
REQ-008 SHALL have port vec_beats, in, BEAT_W: beat count N of that op.
REQ-009 SHALL have port load_use, in, 1: ID instruction needs a load result still in EX.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en, out, 1 each: pipeline register enables.
REQ-011 SHALL have ports ifid_clr, idex_clr, exmem_clr, out, 1 each: synchronous bubble insert into that register.
REQ-012 SHALL have port vec_busy, out, 1: high while in VEC state.
REQ-013 SHALL have port stall_count, out, 16: front-end stall cycle counter.

Function
REQ-014 SHALL implement a two-state FSM {RUN, VEC} plus a BEAT_W-bit down counter rem.
REQ-015 SHALL compute all enable/clear outputs combinationally from state, rem and inputs (zero-cycle latency).
REQ-016 SHALL default to all enables 1 and all clears 0 when no condition below applies.
REQ-017 SHALL, when freeze = mem_req & !mem_ready (any state, highest priority), drive all enables 0 and clears 0, and hold state and rem.
REQ-018 SHALL, in RUN without freeze and with branch_taken, drive ifid_clr=1 and idex_clr=1 with pc_en=1; vec_start and load_use ignored.
REQ-019 SHALL, in RUN without freeze/branch, with vec_start and N>=2: pc_en=ifid_en=idex_en=0, exmem_clr=1; load rem=N-1 and go to VEC.
REQ-020 SHALL treat vec_start with N=0 or N=1 as a single-cycle op (no stall).
REQ-021 SHALL, in RUN without freeze/branch/vec stall and with load_use, drive pc_en=0, ifid_en=0, idex_clr=1 (one bubble).
REQ-022 SHALL, in VEC without freeze and rem>1, drive pc_en=ifid_en=idex_en=0, exmem_clr=1, and decrement rem.
REQ-023 SHALL, in VEC without freeze and rem==1, drive default outputs, set rem=0 and return to RUN; total front stall = N-1 cycles.
REQ-024 SHALL ignore branch_taken, vec_start and load_use while in VEC.
REQ-025 SHALL give any clear priority over its register's enable (clear with enable 0 still inserts bubble).

Reset
REQ-026 SHALL, on reset high at posedge clk, set state=RUN, rem=0, stall_count=0 regardless of other inputs, aborting any vector op.
REQ-027 SHALL drive default outputs (enables 1, clears 0, vec_busy 0) in the first cycle after reset absent freeze.

Configuration
REQ-028 SHALL, with macro STALL_COUNTER_EN defined, increment stall_count every non-reset cycle with pc_en==0, saturating at 0xFFFF.
REQ-029 SHALL, without STALL_COUNTER_EN, drive stall_count constant 0 and contain no counter logic; port remains present.

Verification
REQ-030 SHALL test: vec_start, vec_beats=4 in RUN -> pc_en=0 for exactly 3 cycles, exmem_clr=1 for 3 cycles, vec_busy high 3 cycles, stall_count=3 (macro on).
REQ-031 SHALL test: load_use one cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle only; next cycle defaults.
REQ-032 SHALL test: branch_taken and load_use together -> ifid_clr=idex_clr=1, pc_en=1, no stall.
REQ-033 SHALL test: mem_req=1, mem_ready=0 for 2 cycles mid-VEC (rem=2) -> all enables 0, rem holds 2; after release 2 more VEC cycles complete.
REQ-034 SHALL test: reset during VEC with rem=5 -> next cycle RUN, vec_busy=0, stall_count=0, defaults driven.
REQ-035 SHALL test: vec_start with vec_beats=0 and =1 -> no stall, state stays RUN.
